// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types and default timing thresholds for the Morse key path
//
// Purpose: state enum of the key classifier, symbol enum shared with the
// decoder stage, default unit thresholds and the saturating unit-count helper.
// Ports: none (package).
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        MARK_ERR,
        GAP_SYM,
        GAP_CHAR
    } state_t;

    typedef enum logic [1:0] {
        SYM_DOT,
        SYM_DASH,
        SYM_CHAR_SPACE,
        SYM_WORD_SPACE
    } sym_t;

    localparam int DEF_UNIT_CYCLES     = 1000;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_DOT_MAX_UNITS   = 1;
    localparam int DEF_DASH_MAX_UNITS  = 5;
    localparam int DEF_CHAR_GAP_UNITS  = 3;
    localparam int DEF_WORD_GAP_UNITS  = 7;

    localparam int          UNIT_W   = 4;
    localparam logic [UNIT_W-1:0] UNIT_SAT = 4'd15;

    // Unit counter increment that sticks at 15 instead of wrapping.
    function automatic logic [UNIT_W-1:0] units_inc(input logic [UNIT_W-1:0] u);
        return (u == UNIT_SAT) ? u : u + 4'd1;
    endfunction

endpackage

// File: rtl/morse_key_debounce.sv
// rtl/morse_key_debounce.sv - key line synchroniser and debouncer
//
// Purpose: 2-flop synchroniser followed by a consecutive-cycle debounce.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   i_key        raw key line (asynchronous)
//   o_level      debounced key level
//   o_rise       one-cycle strobe in the cycle before o_level goes 1
//   o_fall       one-cycle strobe in the cycle before o_level goes 0
module morse_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    logic w_differ;
    logic w_flip;

    assign w_differ = r_sync2 ^ r_level;
    // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
    assign w_flip   = w_differ && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Strobes lead the level by one cycle so the timing logic downstream
    // clears its counters on the same edge that the level changes.
    assign o_level = r_level;
    assign o_rise  = w_flip & ~r_level;
    assign o_fall  = w_flip &  r_level;

endmodule

// File: rtl/morse_key_classifier.sv
// rtl/morse_key_classifier.sv - classify debounced key marks/gaps into Morse symbol pulses
//
// Purpose: measure mark and gap lengths in Morse units and emit one-hot,
// one-cycle registered pulses for dot, dash, character space, word space and
// over-long mark.
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   key_in           raw key line, 1 = mark
//   dot_inp          dot pulse
//   dash_inp         dash pulse
//   char_space_inp   character-gap pulse
//   word_space_inp   word-gap pulse
//   err_long_mark    mark-too-long pulse
//   key_level        debounced key level
module morse_key_classifier
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES     = DEF_UNIT_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DOT_MAX_UNITS   = DEF_DOT_MAX_UNITS,
    parameter int DASH_MAX_UNITS  = DEF_DASH_MAX_UNITS,
    parameter int CHAR_GAP_UNITS  = DEF_CHAR_GAP_UNITS,
    parameter int WORD_GAP_UNITS  = DEF_WORD_GAP_UNITS
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic dot_inp,
    output logic dash_inp,
    output logic char_space_inp,
    output logic word_space_inp,
    output logic err_long_mark,
    output logic key_level
);

    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [UNIT_W-1:0] DOT_MAX  = UNIT_W'(DOT_MAX_UNITS);
    localparam logic [UNIT_W-1:0] DASH_MAX = UNIT_W'(DASH_MAX_UNITS);
    localparam logic [UNIT_W-1:0] ERR_UNIT = UNIT_W'(DASH_MAX_UNITS + 1);
    localparam logic [UNIT_W-1:0] CHAR_GAP = UNIT_W'(CHAR_GAP_UNITS);
    localparam logic [UNIT_W-1:0] WORD_GAP = UNIT_W'(WORD_GAP_UNITS);

    logic w_level;
    logic w_rise;
    logic w_fall;
    logic w_edge;
    logic w_wrap;
    logic [UNIT_W-1:0] w_units_nxt;

    logic [PW-1:0]     r_presc;
    logic [UNIT_W-1:0] r_units;
    state_t            r_state;
    state_t            w_state_nxt;

    logic r_dot, r_dash, r_char, r_word, r_err;
    logic w_dot, w_dash, w_char, w_word, w_err;

    morse_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .i_key   (key_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_edge = w_rise | w_fall;
    assign w_wrap = (r_presc == PW'(UNIT_CYCLES - 1));
    // Unit count as it stands after this cycle; a mark ending on the wrap
    // cycle therefore includes the unit just completed.
    assign w_units_nxt = w_wrap ? units_inc(r_units) : r_units;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_units <= '0;
        end else if (w_edge) begin
            r_presc <= '0;
            r_units <= '0;
        end else begin
            r_presc <= w_wrap ? '0 : r_presc + PW'(1);
            r_units <= w_units_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_dot   <= 1'b0;
            r_dash  <= 1'b0;
            r_char  <= 1'b0;
            r_word  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dot   <= w_dot;
            r_dash  <= w_dash;
            r_char  <= w_char;
            r_word  <= w_word;
            r_err   <= w_err;
        end
    end

    // Key edges are tested before unit thresholds so that an edge coinciding
    // with a threshold suppresses the threshold pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_dot       = 1'b0;
        w_dash      = 1'b0;
        w_char      = 1'b0;
        w_word      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) w_state_nxt = MARK;
            end
            MARK: begin
                if (w_fall) begin
                    if (w_units_nxt <= DOT_MAX) begin
                        w_dot       = 1'b1;
                        w_state_nxt = GAP_SYM;
                    end else if (w_units_nxt <= DASH_MAX) begin
                        w_dash      = 1'b1;
                        w_state_nxt = GAP_SYM;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_units_nxt == ERR_UNIT) begin
                    w_err       = 1'b1;
                    w_state_nxt = MARK_ERR;
                end
            end
            MARK_ERR: begin
                if (w_fall) w_state_nxt = IDLE;
            end
            GAP_SYM: begin
                if (w_rise) begin
                    w_state_nxt = MARK;
                end else if (w_units_nxt == CHAR_GAP) begin
                    w_char      = 1'b1;
                    w_state_nxt = GAP_CHAR;
                end
            end
            GAP_CHAR: begin
                if (w_rise) begin
                    w_state_nxt = MARK;
                end else if (w_units_nxt == WORD_GAP) begin
                    w_word      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign dot_inp        = r_dot;
    assign dash_inp       = r_dash;
    assign char_space_inp = r_char;
    assign word_space_inp = r_word;
    assign err_long_mark  = r_err;
    assign key_level      = w_level;

endmodule

// File: tb/tb_morse_key_classifier.sv
// tb/tb_morse_key_classifier.sv - directed self-checking bench for morse_key_classifier
module tb_morse_key_classifier;

    localparam int UC = 4;
    localparam int DC = 8;

    // Event codes recorded by the monitor.
    localparam int E_DOT  = 1;
    localparam int E_DASH = 2;
    localparam int E_CHAR = 3;
    localparam int E_WORD = 4;
    localparam int E_ERR  = 5;
    localparam int E_RISE = 6;
    localparam int E_FALL = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_in = 1'b0;
    logic dot_inp, dash_inp, char_space_inp, word_space_inp, err_long_mark, key_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int oh_bad = 0;
    int ev_code[$];
    int ev_time[$];
    logic prev_level = 1'b0;

    // A debounced mark lasts at least DC = 8 cycles = 2 units here, so the dot
    // threshold is 2 units to leave both dots and dashes reachable.
    morse_key_classifier #(
        .UNIT_CYCLES     (UC),
        .DEBOUNCE_CYCLES (DC),
        .DOT_MAX_UNITS   (2),
        .DASH_MAX_UNITS  (5),
        .CHAR_GAP_UNITS  (3),
        .WORD_GAP_UNITS  (7)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key_in),
        .dot_inp        (dot_inp),
        .dash_inp       (dash_inp),
        .char_space_inp (char_space_inp),
        .word_space_inp (word_space_inp),
        .err_long_mark  (err_long_mark),
        .key_level      (key_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            prev_level = 1'b0;
        end else begin
            if (key_level && !prev_level) begin ev_code.push_back(E_RISE); ev_time.push_back(cyc); end
            if (!key_level && prev_level) begin ev_code.push_back(E_FALL); ev_time.push_back(cyc); end
            if (dot_inp)        begin ev_code.push_back(E_DOT);  ev_time.push_back(cyc); end
            if (dash_inp)       begin ev_code.push_back(E_DASH); ev_time.push_back(cyc); end
            if (char_space_inp) begin ev_code.push_back(E_CHAR); ev_time.push_back(cyc); end
            if (word_space_inp) begin ev_code.push_back(E_WORD); ev_time.push_back(cyc); end
            if (err_long_mark)  begin ev_code.push_back(E_ERR);  ev_time.push_back(cyc); end
            if ($countones({dot_inp, dash_inp, char_space_inp, word_space_inp, err_long_mark}) > 1)
                oh_bad++;
            prev_level = key_level;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        key_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int n_ev(input int code, input int base);
        int n = 0;
        for (int i = base; i < ev_code.size(); i++)
            if (ev_code[i] == code) n++;
        return n;
    endfunction

    function automatic int t_ev(input int code, input int base);
        for (int i = base; i < ev_code.size(); i++)
            if (ev_code[i] == code) return ev_time[i];
        return -1000;
    endfunction

    initial begin
        int base;
        int seq[$];
        int exp_seq[6];

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_dot",   int'(dot_inp), 0);
        chk("rst_dash",  int'(dash_inp), 0);
        chk("rst_char",  int'(char_space_inp), 0);
        chk("rst_word",  int'(word_space_inp), 0);
        chk("rst_err",   int'(err_long_mark), 0);
        chk("rst_level", int'(key_level), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b0, 5);

        // Dot (8-cycle mark ends on a wrap -> 2 units), then full gap
        base = ev_code.size();
        hold(1'b1, 8);
        hold(1'b0, 50);
        chk("dot_count",      n_ev(E_DOT, base), 1);
        chk("dot_no_dash",    n_ev(E_DASH, base), 0);
        chk("dot_no_err",     n_ev(E_ERR, base), 0);
        chk("dot_latency",    t_ev(E_DOT, base) - t_ev(E_FALL, base), 0);
        chk("char_after_fall", t_ev(E_CHAR, base) - t_ev(E_FALL, base), 12);
        chk("word_after_char", t_ev(E_WORD, base) - t_ev(E_CHAR, base), 16);
        chk("dot_char_count", n_ev(E_CHAR, base), 1);
        chk("dot_word_count", n_ev(E_WORD, base), 1);

        // Dash: 12-cycle mark, third unit completes on the release cycle
        base = ev_code.size();
        hold(1'b1, 12);
        hold(1'b0, 50);
        chk("dash_count",     n_ev(E_DASH, base), 1);
        chk("dash_no_dot",    n_ev(E_DOT, base), 0);
        chk("dash_latency",   t_ev(E_DASH, base) - t_ev(E_FALL, base), 0);
        chk("dash_to_char",   t_ev(E_CHAR, base) - t_ev(E_DASH, base), 12);
        chk("dash_word_count", n_ev(E_WORD, base), 1);

        // 11-cycle mark: only 2 complete units -> dot
        base = ev_code.size();
        hold(1'b1, 11);
        hold(1'b0, 50);
        chk("m11_dot",  n_ev(E_DOT, base), 1);
        chk("m11_dash", n_ev(E_DASH, base), 0);

        // Over-long mark
        base = ev_code.size();
        hold(1'b1, 30);
        hold(1'b0, 50);
        chk("err_count",   n_ev(E_ERR, base), 1);
        chk("err_time",    t_ev(E_ERR, base) - t_ev(E_RISE, base), 24);
        chk("err_no_sym",  n_ev(E_DOT, base) + n_ev(E_DASH, base), 0);
        chk("err_no_space", n_ev(E_CHAR, base) + n_ev(E_WORD, base), 0);
        chk("err_fall",    n_ev(E_FALL, base), 1);

        // Bounces shorter than the debounce window
        base = ev_code.size();
        repeat (4) begin
            hold(1'b1, 5);
            hold(1'b0, 3);
        end
        hold(1'b0, 20);
        chk("glitch_events", ev_code.size() - base, 0);
        chk("glitch_level",  int'(key_level), 0);

        // dot, short gap, dash, 5-unit gap, dot, full gap
        base = ev_code.size();
        hold(1'b1, 8);
        hold(1'b0, 8);
        hold(1'b1, 12);
        hold(1'b0, 20);
        hold(1'b1, 8);
        hold(1'b0, 50);
        exp_seq = '{E_DOT, E_DASH, E_CHAR, E_DOT, E_CHAR, E_WORD};
        for (int i = base; i < ev_code.size(); i++)
            if (ev_code[i] <= E_ERR) seq.push_back(ev_code[i]);
        chk("seq_len", seq.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < seq.size()) chk($sformatf("seq_%0d", i), seq[i], exp_seq[i]);
        chk("one_hot", oh_bad, 0);

        // Reset mid-mark
        key_in = 1'b1;
        repeat (DC + 2 + 6) @(posedge clk);
        #1;
        chk("pre_rst_level", int'(key_level), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_level", int'(key_level), 0);
        chk("arst_pulses", int'({dot_inp, dash_inp, char_space_inp, word_space_inp, err_long_mark}), 0);
        key_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        base = ev_code.size();
        hold(1'b0, 60);
        chk("post_rst_events", ev_code.size() - base, 0);
        chk("one_hot_final", oh_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
